// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed stream loader for the instruction ROM.
// Holds the core in reset until a length/data/checksum frame verifies.
module imem_loader #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  out_ready,
    input  logic                  in_reload,
    output logic                  out_imem_we,
    output logic [ADDR_WIDTH-1:0] out_imem_addr,
    output logic [31:0]           out_imem_data,
    output logic                  out_core_reset,
    output logic                  out_done,
    output logic                  out_error,
    output logic [ADDR_WIDTH:0]   out_words_loaded
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t                state;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   cnt;
    logic [31:0]           csum;
    logic                  xfer;

    assign out_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHECK);
    assign xfer      = in_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_LEN;
            len              <= '0;
            cnt              <= '0;
            csum             <= '0;
            out_imem_we      <= 1'b0;
            out_imem_addr    <= '0;
            out_imem_data    <= '0;
            out_core_reset   <= 1'b1;
            out_done         <= 1'b0;
            out_error        <= 1'b0;
            out_words_loaded <= '0;
        end else begin
            out_imem_we <= 1'b0;
            // A reload wins over any transfer presented in the same cycle.
            if (in_reload) begin
                if (state != S_LEN) begin
                    state            <= S_LEN;
                    out_core_reset   <= 1'b1;
                    out_done         <= 1'b0;
                    out_error        <= 1'b0;
                    out_words_loaded <= '0;
                end
            end else begin
                case (state)
                    S_LEN: begin
                        if (xfer) begin
                            if (in_data == 32'd0 || in_data > DEPTH_W) begin
                                state     <= S_ERR;
                                out_error <= 1'b1;
                            end else begin
                                len              <= in_data[ADDR_WIDTH:0];
                                cnt              <= '0;
                                csum             <= '0;
                                out_words_loaded <= '0;
                                state            <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (xfer) begin
                            out_imem_we      <= 1'b1;
                            out_imem_addr    <= cnt[ADDR_WIDTH-1:0];
                            out_imem_data    <= in_data;
                            csum             <= csum ^ in_data;
                            cnt              <= cnt + 1'b1;
                            out_words_loaded <= cnt + 1'b1;
                            if (cnt == len - 1'b1) state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (xfer) begin
                            if (in_data == csum) begin
                                state          <= S_RUN;
                                out_core_reset <= 1'b0;
                                out_done       <= 1'b1;
                            end else begin
                                state     <= S_ERR;
                                out_error <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          out_ready;
    logic          in_reload;
    logic          out_imem_we;
    logic [AW-1:0] out_imem_addr;
    logic [31:0]   out_imem_data;
    logic          out_core_reset;
    logic          out_done;
    logic          out_error;
    logic [AW:0]   out_words_loaded;

    imem_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .in_reload(in_reload), .out_imem_we(out_imem_we),
        .out_imem_addr(out_imem_addr), .out_imem_data(out_imem_data),
        .out_core_reset(out_core_reset), .out_done(out_done), .out_error(out_error),
        .out_words_loaded(out_words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Every ROM write must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (out_imem_we) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_we", {31'b0, out_imem_we}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check_eq("wr_addr", {22'b0, out_imem_addr}, {22'b0, e.addr});
                check_eq("wr_data", out_imem_data, e.data);
                check_eq("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic xfer(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic xfer_data(input logic [31:0] w, input int addr);
        wr_t e;
        e.addr = addr[AW-1:0];
        e.data = w;
        e.cyc  = cyc + 1;
        sb.push_back(e);
        xfer(w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reload();
        in_reload = 1'b1;
        @(posedge clk);
        #1;
        in_reload = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, {31'b0, out_ready}, 32'd1);
        check_eq({tag, "_we"}, {31'b0, out_imem_we}, 32'd0);
        check_eq({tag, "_addr"}, {22'b0, out_imem_addr}, 32'd0);
        check_eq({tag, "_data"}, out_imem_data, 32'd0);
        check_eq({tag, "_core_reset"}, {31'b0, out_core_reset}, 32'd1);
        check_eq({tag, "_done"}, {31'b0, out_done}, 32'd0);
        check_eq({tag, "_error"}, {31'b0, out_error}, 32'd0);
        check_eq({tag, "_words"}, {21'b0, out_words_loaded}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0, w1, w2, cs;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_reload = 1'b0;
        idle(2);
        reset = 1'b0;
        check_reset_vals("rst");

        // Test 1: good two-word frame.
        xfer(32'd2);
        xfer_data(32'h00100093, 0);
        xfer_data(32'h00200113, 1);
        check_eq("t1_core_reset_pre", {31'b0, out_core_reset}, 32'd1);
        xfer(32'h00300180);
        check_eq("t1_core_reset", {31'b0, out_core_reset}, 32'd0);
        check_eq("t1_done", {31'b0, out_done}, 32'd1);
        check_eq("t1_words", {21'b0, out_words_loaded}, 32'd2);
        check_eq("t1_ready", {31'b0, out_ready}, 32'd0);
        xfer(32'd1);
        check_eq("t1_run_hold", {31'b0, out_done}, 32'd1);
        reload();
        check_eq("t1_rl_core_reset", {31'b0, out_core_reset}, 32'd1);
        check_eq("t1_rl_done", {31'b0, out_done}, 32'd0);
        check_eq("t1_rl_words", {21'b0, out_words_loaded}, 32'd0);

        // Test 2: checksum mismatch.
        xfer(32'd2);
        xfer_data(32'h00100093, 0);
        xfer_data(32'h00200113, 1);
        xfer(32'h00300181);
        check_eq("t2_error", {31'b0, out_error}, 32'd1);
        check_eq("t2_core_reset", {31'b0, out_core_reset}, 32'd1);
        check_eq("t2_ready", {31'b0, out_ready}, 32'd0);
        xfer(32'd5);
        check_eq("t2_err_hold", {31'b0, out_error}, 32'd1);
        reload();
        check_eq("t2_rl_error", {31'b0, out_error}, 32'd0);
        check_eq("t2_rl_ready", {31'b0, out_ready}, 32'd1);

        // Test 3: illegal headers, then recovery.
        xfer(32'd0);
        check_eq("t3_hdr0_error", {31'b0, out_error}, 32'd1);
        reload();
        xfer(32'd1025);
        check_eq("t3_hdr1025_error", {31'b0, out_error}, 32'd1);
        check_eq("t3_ready", {31'b0, out_ready}, 32'd0);
        reload();
        xfer(32'd1);
        xfer_data(32'h00000013, 0);
        xfer(32'h00000013);
        check_eq("t3_done", {31'b0, out_done}, 32'd1);
        reload();

        // Test 4: gaps between data transfers.
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        cs = w0 ^ w1 ^ w2;
        xfer(32'd3);
        xfer_data(w0, 0);
        idle(1);
        xfer_data(w1, 1);
        idle(1);
        xfer_data(w2, 2);
        xfer(cs);
        check_eq("t4_done", {31'b0, out_done}, 32'd1);
        check_eq("t4_words", {21'b0, out_words_loaded}, 32'd3);
        reload();

        // Test 5: reload with a simultaneous transfer mid-frame.
        xfer(32'd4);
        xfer_data(32'h11111111, 0);
        xfer_data(32'h22222222, 1);
        in_reload = 1'b1;
        xfer(32'h33333333);
        in_reload = 1'b0;
        check_eq("t5_ready", {31'b0, out_ready}, 32'd1);
        check_eq("t5_words", {21'b0, out_words_loaded}, 32'd0);
        check_eq("t5_core_reset", {31'b0, out_core_reset}, 32'd1);
        xfer(32'd1);
        xfer_data(32'hcafef00d, 0);
        xfer(32'hcafef00d);
        check_eq("t5_refr_done", {31'b0, out_done}, 32'd1);

        // Test 6: reset in S_RUN, then reset with a data word in S_DATA.
        in_valid = 1'b1; in_data = 32'h5;
        do_reset();
        in_valid = 1'b0;
        check_reset_vals("t6_run");
        xfer(32'd2);
        xfer_data(32'h0badc0de, 0);
        in_valid = 1'b1; in_data = 32'hdeadbeef;
        do_reset();
        in_valid = 1'b0;
        check_reset_vals("t6_data");
        idle(1);
        check_eq("t6_no_we", {31'b0, out_imem_we}, 32'd0);

        // Full-depth frame: last write lands at DEPTH-1.
        cs = '0;
        xfer(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            w0 = $urandom;
            cs = cs ^ w0;
            xfer_data(w0, i);
        end
        check_eq("full_words", {21'b0, out_words_loaded}, DEPTH);
        xfer(cs);
        check_eq("full_done", {31'b0, out_done}, 32'd1);

        idle(2);
        check_eq("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
